uart_receiver: RTL and testbench

- Asynchronous serial receiver for 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity).
- Bit period is set at run time in system-clock cycles.
- Feeds the serial-keyboard decoder: a one-cycle `valid` pulse carries each received byte; a one-cycle `starting` pulse marks each detected start edge, so downstream logic can clear key state before the next byte arrives.

---
 rtl/uart_receiver.sv | 119 +++++++++++
 tb/tb_uart_receiver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 serial receiver with start-edge and byte-valid pulses
module uart_receiver #(
  parameter int DIV_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ser_rx,
  input  logic [DIV_WIDTH-1:0] cfg_divider,
  output logic [7:0]           data,
  output logic                 valid,
  output logic                 starting
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rxs;
  logic [DIV_WIDTH-1:0] counter;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_eff;
  logic [DIV_WIDTH-1:0] half;
  logic [DIV_WIDTH-1:0] last_cnt;
  logic [2:0]           bit_idx;
  logic [7:0]           shift;

  // Dividers below 2 would leave no room for a mid-bit sample point.
  assign div_eff  = (cfg_divider < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : cfg_divider;
  assign half     = div_q >> 1;
  assign last_cnt = div_q - DIV_WIDTH'(1);

  // Two-flop synchronizer; both stages idle high so reset does not look like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= ser_rx;
      rxs     <= rx_meta;
    end
  end

  // Frame FSM: start-bit check H cycles after the start pulse, then one sample per bit period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      counter  <= '0;
      div_q    <= DIV_WIDTH'(2);
      bit_idx  <= 3'd0;
      shift    <= 8'h00;
      data     <= 8'h00;
      valid    <= 1'b0;
      starting <= 1'b0;
    end else begin
      valid    <= 1'b0;
      starting <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            starting <= 1'b1;
            counter  <= '0;
            div_q    <= div_eff;
            state    <= START;
          end
        end
        START: begin
          if (counter == half) begin
            counter <= '0;
            bit_idx <= 3'd0;
            // A line that is high again at mid start bit was only a glitch.
            state   <= rxs ? IDLE : DATA;
          end else begin
            counter <= counter + DIV_WIDTH'(1);
          end
        end
        DATA: begin
          if (counter == last_cnt) begin
            counter <= '0;
            shift   <= {rxs, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            counter <= counter + DIV_WIDTH'(1);
          end
        end
        STOP: begin
          if (counter == last_cnt) begin
            counter <= '0;
            if (rxs) begin
              data  <= shift;
              valid <= 1'b1;
              state <= IDLE;
            end else begin
              // Framing error or break: drop the byte and wait for the line to recover.
              state <= WAIT_IDLE;
            end
          end else begin
            counter <= counter + DIV_WIDTH'(1);
          end
        end
        WAIT_IDLE: begin
          if (rxs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - table-driven and scoreboard checks for uart_receiver
module tb_uart_receiver;

  logic        clk;
  logic        reset;
  logic        ser_rx;
  logic [31:0] cfg_divider;
  logic [7:0]  data;
  logic        valid;
  logic        starting;

  uart_receiver #(.DIV_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .ser_rx     (ser_rx),
    .cfg_divider(cfg_divider),
    .data       (data),
    .valid      (valid),
    .starting   (starting)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         div;
    logic [7:0] b;
    logic       stop;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] exp_q [$];
  logic [7:0] exp_data;
  int         errors;
  int         checks;
  int         cyc;
  int         start_cnt;
  int         valid_cnt;
  int         last_start;
  int         last_valid;
  int         fall_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle; outputs are observed on the falling edge and fed to the scoreboard.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    cyc++;
    if (starting) begin
      start_cnt++;
      last_start = cyc;
    end
    if (valid) begin
      valid_cnt++;
      last_valid = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: valid with data=%0h, expected no byte", data);
      end else begin
        e = exp_q.pop_front();
        if (data !== e) begin
          errors++;
          $display("FAIL sb_data: got %0h expected %0h", data, e);
        end
      end
      if (starting) begin
        errors++;
        $display("FAIL overlap: valid=1 starting=1 expected not both");
      end
    end
  endtask

  task automatic idle(input int n);
    ser_rx = 1'b1;
    repeat (n) tick();
  endtask

  // Drives one frame; the line is left at the stop-bit level so frames can abut.
  task automatic send_frame(input logic [7:0] b, input int d, input logic stop_bit);
    if (stop_bit) begin
      exp_q.push_back(b);
      exp_data = b;
    end
    ser_rx   = 1'b0;
    fall_cyc = cyc;
    repeat (d) tick();
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (d) tick();
    end
    ser_rx = stop_bit;
    repeat (d) tick();
  endtask

  int s0;
  int v0;

  initial begin
    errors = 0; checks = 0; cyc = 0;
    start_cnt = 0; valid_cnt = 0; last_start = 0; last_valid = 0; fall_cyc = 0;
    exp_data = 8'h00;
    vecs[0] = '{div: 4,  b: 8'hA5, stop: 1'b1};
    vecs[1] = '{div: 5,  b: 8'h3C, stop: 1'b1};
    vecs[2] = '{div: 16, b: 8'h00, stop: 1'b1};
    vecs[3] = '{div: 8,  b: 8'hFF, stop: 1'b1};
    vecs[4] = '{div: 13, b: 8'h81, stop: 1'b0};
    vecs[5] = '{div: 7,  b: 8'h6E, stop: 1'b1};

    reset = 1'b1;
    ser_rx = 1'b1;
    cfg_divider = 32'd8;
    repeat (3) tick();
    chk("reset_data", {24'h0, data}, 32'h00);
    chk("reset_valid", {31'h0, valid}, 32'h0);
    chk("reset_starting", {31'h0, starting}, 32'h0);
    reset = 1'b0;
    idle(1000);
    chk("idle_starts", start_cnt, 0);
    chk("idle_valids", valid_cnt, 0);
    chk("idle_data", {24'h0, data}, 32'h00);

    // 'A' at divider 8 with latency checks
    s0 = start_cnt; v0 = valid_cnt;
    send_frame(8'h41, 8, 1'b1);
    idle(40);
    chk("a_starts", start_cnt - s0, 1);
    chk("a_valids", valid_cnt - v0, 1);
    chk("a_start_latency", last_start - fall_cyc, 3);
    chk("a_valid_latency", last_valid - last_start, 4 + 9 * 8 + 1);
    chk("a_data", {24'h0, data}, 32'h41);
    chk("a_sb_empty", exp_q.size(), 0);

    // table of single frames, including a framing error
    for (int k = 0; k < 6; k++) begin
      logic [7:0] prev;
      prev = exp_data;
      cfg_divider = vecs[k].div;
      s0 = start_cnt; v0 = valid_cnt;
      send_frame(vecs[k].b, vecs[k].div, vecs[k].stop);
      idle(3 * vecs[k].div + 10);
      chk($sformatf("vec%0d_starts", k), start_cnt - s0, 1);
      chk($sformatf("vec%0d_valids", k), valid_cnt - v0, vecs[k].stop ? 1 : 0);
      chk($sformatf("vec%0d_data", k), {24'h0, data},
          {24'h0, vecs[k].stop ? vecs[k].b : prev});
      chk($sformatf("vec%0d_sb_empty", k), exp_q.size(), 0);
    end

    // back-to-back frames at divider 217
    cfg_divider = 32'd217;
    s0 = start_cnt; v0 = valid_cnt;
    send_frame(8'h0D, 217, 1'b1);
    send_frame(8'h7A, 217, 1'b1);
    idle(700);
    chk("b2b_starts", start_cnt - s0, 2);
    chk("b2b_valids", valid_cnt - v0, 2);
    chk("b2b_data", {24'h0, data}, 32'h7A);
    chk("b2b_sb_empty", exp_q.size(), 0);

    // two-cycle glitch is rejected, next frame still received
    cfg_divider = 32'd8;
    s0 = start_cnt; v0 = valid_cnt;
    ser_rx = 1'b0;
    repeat (2) tick();
    idle(40);
    chk("glitch_starts", start_cnt - s0, 1);
    chk("glitch_valids", valid_cnt - v0, 0);
    send_frame(8'h55, 8, 1'b1);
    idle(40);
    chk("glitch_next_data", {24'h0, data}, 32'h55);
    chk("glitch_next_valids", valid_cnt - v0, 1);
    chk("glitch_sb_empty", exp_q.size(), 0);

    // stop bit 0 followed by a held-low line
    s0 = start_cnt; v0 = valid_cnt;
    send_frame(8'h33, 8, 1'b0);
    repeat (200) tick();
    chk("break_starts", start_cnt - s0, 1);
    chk("break_valids", valid_cnt - v0, 0);
    chk("break_data", {24'h0, data}, 32'h55);
    idle(30);
    chk("break_release_starts", start_cnt - s0, 1);
    send_frame(8'h96, 8, 1'b1);
    idle(40);
    chk("break_next_data", {24'h0, data}, 32'h96);
    chk("break_next_starts", start_cnt - s0, 2);

    // reset during data bit 4 of 8'hF0 (bits 4..7 and stop are high)
    s0 = start_cnt; v0 = valid_cnt;
    ser_rx = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 4; i++) begin
      ser_rx = 1'b0;
      repeat (8) tick();
    end
    ser_rx = 1'b1;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    chk("rst_mid_data", {24'h0, data}, 32'h00);
    chk("rst_mid_valid", {31'h0, valid}, 32'h0);
    chk("rst_mid_starting", {31'h0, starting}, 32'h0);
    repeat (4) tick();
    reset = 1'b0;
    idle(8 * 4 + 40);
    chk("rst_starts", start_cnt - s0, 1);
    chk("rst_valids", valid_cnt - v0, 0);
    chk("rst_data_held", {24'h0, data}, 32'h00);
    send_frame(8'h5A, 8, 1'b1);
    idle(40);
    chk("rst_next_data", {24'h0, data}, 32'h5A);
    chk("rst_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
